// File: rtl/bg_cpu_access_arbiter_pkg.sv
// Shared types for the background RAM CPU-side arbiter:
// FSM states, bank encoding and the default RAM address width.
package bg_cpu_access_arbiter_pkg;

    localparam int BG_AW = 11;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        RDLAT,
        HOLD
    } state_t;

    typedef enum logic {
        BANK_LO = 1'b0,
        BANK_HI = 1'b1
    } bank_t;

    // Lo bank wins whenever its select is low, even if hi is also selected.
    function automatic bank_t bank_pick(input logic sel_lo_n);
        return sel_lo_n ? BANK_HI : BANK_LO;
    endfunction

endpackage

// File: rtl/bg_wait_counter.sv
// Saturating minimum-wait counter and active-low Z80 WAIT generation
// for the background RAM arbiter.
module bg_wait_counter #(
    parameter int MIN_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic count,
    input  logic busy,
    input  logic hold,
    output logic bg_wait
);
    localparam int CW = (MIN_WAIT < 1) ? 1 : $clog2(MIN_WAIT + 1);
    localparam logic [CW-1:0] WMAX = CW'(MIN_WAIT);

    logic [CW-1:0] wcnt;
    logic          short;

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt <= '0;
        end else if (start) begin
            wcnt <= '0;
        end else if (count && (wcnt < WMAX)) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    // The budget only gates release in HOLD; an idle bus never waits.
    assign short   = hold && (wcnt < WMAX);
    assign bg_wait = !(start || busy || short);

endmodule

// File: rtl/bg_cpu_access_arbiter.sv
// Z80 access to the background tile RAM pair over port B, held off
// with WAIT until a slot is free of renderer tile fetches.
module bg_cpu_access_arbiter
    import bg_cpu_access_arbiter_pkg::*;
#(
    parameter int MIN_WAIT = 2,
    parameter int RAM_LAT  = 1,
    parameter int AW       = BG_AW
) (
    input  logic          master_clk,
    input  logic          reset,
    input  logic          BACKGRAM_1,
    input  logic          BACKGRAM_2,
    input  logic          Z80_RD,
    input  logic          Z80_WR,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [7:0]    CPU_DIN,
    input  logic          bg_fetch,
    input  logic [7:0]    ram_q_lo,
    input  logic [7:0]    ram_q_hi,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we_lo,
    output logic          ram_we_hi,
    output logic [7:0]    cpu_dout,
    output logic          BG_WAIT
);
    localparam int LW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(RAM_LAT - 1);

    state_t        state;
    state_t        state_nx;

    logic          sel;
    logic          strobe;
    logic          request;
    logic          start;
    logic          issue;
    logic          lat_done;
    logic          in_idle;
    logic          in_hold;

    logic [AW-1:0] lat_addr;
    logic [7:0]    lat_data;
    bank_t         lat_bank;
    logic          lat_wr;
    logic [LW-1:0] lat_cnt;

    assign sel      = !BACKGRAM_1 || !BACKGRAM_2;
    assign strobe   = !Z80_RD || !Z80_WR;
    assign request  = sel && strobe;
    assign in_idle  = (state == IDLE);
    assign in_hold  = (state == HOLD);
    assign start    = request && in_idle;
    assign issue    = (state == ARB) && request && !bg_fetch;
    assign lat_done = (lat_cnt == LAT_LAST);

    always_ff @(posedge master_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (request) begin
                    state_nx = ARB;
                end
            end
            ARB: begin
                if (!request) begin
                    state_nx = IDLE;
                end else if (!bg_fetch) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!lat_wr) begin
                    state_nx = RDLAT;
                end else begin
                    state_nx = request ? HOLD : IDLE;
                end
            end
            RDLAT: begin
                if (lat_done) begin
                    state_nx = request ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!request) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Access captured at start so later bus changes cannot corrupt it.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_bank <= BANK_LO;
            lat_wr   <= 1'b0;
        end else if (start) begin
            lat_addr <= CPU_ADDR;
            lat_data <= CPU_DIN;
            lat_bank <= bank_pick(BACKGRAM_1);
            lat_wr   <= !Z80_WR;
        end
    end

    // Port B only moves on issue, so it holds steady while idle.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_we_lo <= 1'b0;
            ram_we_hi <= 1'b0;
        end else begin
            ram_we_lo <= issue && lat_wr && (lat_bank == BANK_LO);
            ram_we_hi <= issue && lat_wr && (lat_bank == BANK_HI);
            if (issue) begin
                ram_addr <= lat_addr;
                if (lat_wr) begin
                    ram_din <= lat_data;
                end
            end
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            lat_cnt  <= '0;
            cpu_dout <= '0;
        end else begin
            if (state == ISSUE) begin
                lat_cnt <= '0;
            end else if ((state == RDLAT) && !lat_done) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if ((state == RDLAT) && lat_done) begin
                cpu_dout <= (lat_bank == BANK_HI) ? ram_q_hi : ram_q_lo;
            end
        end
    end

    bg_wait_counter #(
        .MIN_WAIT(MIN_WAIT)
    ) u_wait (
        .clk    (master_clk),
        .reset  (reset),
        .start  (start),
        .count  (!in_idle),
        .busy   (!in_idle && !in_hold),
        .hold   (in_hold),
        .bg_wait(BG_WAIT)
    );

endmodule
